jk_counter_sched: RTL and testbench

Scheduler that shares one 4-bit JK-style synchronous up-counter among NREQ requesters.
- Arbitrates requests round-robin and latches the winner's terminal value.
- Runs the counter from 0 to that value and pulses a per-requester done.
- Exports per-bit toggle enables (J=K drive) so a mirrored JK flip-flop chain tracks the internal count exactly.

---
 rtl/jk_counter_sched.sv | 131 +++++++++++++
 tb/tb_jk_counter_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_counter_sched.sv
// Round-robin scheduler sharing one up-counter among NREQ requesters.
// Exports per-bit J=K toggle enables so an external JK chain can mirror count.
module jk_counter_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   limit,
    input  logic                    abort,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic [WIDTH-1:0]        count,
    output logic [WIDTH-1:0]        toggle,
    output logic [NREQ-1:0]         done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, COUNT, DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   rr, rr_nxt;
    logic [IW-1:0]   win;
    logic            win_vld;
    logic [WIDTH-1:0] lim, lim_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic            cancel;
    logic            carry;
    int              idx;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        next_idx = (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Search upward from the rr pointer, wrapping modulo NREQ
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_vld && req[IW'(idx)]) begin
                win     = IW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    assign cancel = abort || !req[owner];

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr;
        lim_nxt   = lim;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = GRANT;
                    owner_nxt = win;
                    lim_nxt   = limit[int'(win)*WIDTH +: WIDTH];
                end
            end
            GRANT: begin
                count_nxt = '0;
                if (cancel) begin
                    state_nxt = IDLE;
                    rr_nxt    = next_idx(owner);
                end else begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                // Cancellation wins over reaching the terminal value
                if (cancel) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                    rr_nxt    = next_idx(owner);
                end else if (count == lim) begin
                    state_nxt = DONE;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                rr_nxt    = next_idx(owner);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            rr    <= '0;
            lim   <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            rr    <= rr_nxt;
            lim   <= lim_nxt;
            count <= count_nxt;
        end
    end

    // Bit i toggles when all lower bits are 1, matching a JK ripple-free up-counter
    always_comb begin
        grant  = '0;
        done   = '0;
        toggle = '0;
        carry  = 1'b1;
        busy   = (state != IDLE);
        if (state != IDLE) grant[owner] = 1'b1;
        if (state == DONE) done[owner] = 1'b1;
        if (state == COUNT && count != lim) begin
            for (int i = 0; i < WIDTH; i++) begin
                toggle[i] = carry;
                carry     = carry & count[i];
            end
        end
    end

endmodule

// File: tb/tb_jk_counter_sched.sv
// Directed and randomized bench for jk_counter_sched against a job-level
// reference model (cycle offset within the current job).
module tb_jk_counter_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] limit;
    logic                  abort;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic [WIDTH-1:0]      toggle;
    logic [NREQ-1:0]       done;

    jk_counter_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .req(req), .limit(limit), .abort(abort),
        .grant(grant), .busy(busy), .count(count), .toggle(toggle), .done(done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a job is GRANT at t=0, counting at t=1..lim+1 (count=t-1),
    // completion at t=lim+2.
    bit m_active;
    int m_owner, m_lim, m_t, m_rr, m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_owner = 0; m_lim = 0; m_t = 0; m_rr = 0; m_count = 0;
    endtask

    task automatic check_all();
        int g, d, tg;
        bit in_count;
        g        = m_active ? (1 << m_owner) : 0;
        in_count = m_active && m_t >= 1 && m_t <= m_lim + 1;
        d        = (m_active && m_t == m_lim + 2) ? g : 0;
        tg       = (in_count && m_count < m_lim) ? (((m_count + 1) ^ m_count) & 15) : 0;
        chk("grant",  32'(grant),  g);
        chk("busy",   32'(busy),   32'(m_active));
        chk("count",  32'(count),  m_count);
        chk("toggle", 32'(toggle), tg);
        chk("done",   32'(done),   d);
    endtask

    task automatic model_step();
        int rq, id;
        rq = int'(req);
        if (!m_active) begin
            for (int k = 0; k < NREQ; k++) begin
                id = (m_rr + k) % NREQ;
                if (!m_active && ((rq >> id) & 1) == 1) begin
                    m_active = 1;
                    m_owner  = id;
                    m_lim    = int'((limit >> (id * WIDTH)) & 16'hF);
                    m_t      = 0;
                end
            end
        end else if (m_t <= m_lim + 1 && (abort || ((rq >> m_owner) & 1) == 0)) begin
            m_active = 0;
            m_count  = 0;
            m_rr     = (m_owner + 1) % NREQ;
        end else if (m_t == m_lim + 2) begin
            m_active = 0;
            m_rr     = (m_owner + 1) % NREQ;
        end else begin
            m_t = m_t + 1;
            if (m_t <= m_lim + 1) m_count = m_t - 1;
        end
    endtask

    task automatic cyc();
        check_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_t(input int t, input string tag);
        int n = 0;
        while (!(m_active && m_t == t) && n < 60) begin cyc(); n++; end
        chk(tag, 32'(n < 60), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (m_active && n < 60) begin cyc(); n++; end
        chk(tag, 32'(n < 60), 1);
    endtask

    int pulses, n, gap;
    logic [NREQ-1:0] exp_g [5];

    initial begin
        model_reset();
        reset = 1'b1; req = '0; limit = '0; abort = 1'b0;
        @(negedge clk); @(negedge clk);
        check_all();
        reset = 1'b0;

        // 1: single job, limit 3
        req = 4'b0001; limit = 16'h0003;
        cyc();
        chk("t1_grant", 32'(grant), 32'h1);
        wait_t(5, "t1_reach_done");
        chk("t1_done",  32'(done),  32'h1);
        chk("t1_count", 32'(count), 32'h3);
        cyc();
        req = '0;
        cyc();
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // 2: all requesting, all limits 1, round-robin order and 5-cycle jobs
        reset = 1'b1; #1; model_reset(); @(negedge clk); reset = 1'b0;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        req = 4'b1111; limit = 16'h1111;
        for (int j = 0; j < 5; j++) begin
            n = 0; pulses = 0;
            while (!(m_active && m_t == 0) && n < 20) begin
                if (done != 0) pulses++;
                cyc(); n++;
            end
            chk("t2_grant", 32'(grant), 32'(exp_g[j]));
            if (j > 0) begin
                gap = n + 1;
                chk("t2_job_len", gap, 5);
                chk("t2_done_pulses", pulses, 1);
            end
            cyc();
        end
        req = '0;
        wait_idle("t2_idle");
        cyc();

        // 3: limit 0, then limit 15 with no wrap
        limit = 16'h0000; req = 4'b0001;
        wait_t(1, "t3a_count");
        chk("t3a_toggle", 32'(toggle), 32'h0);
        wait_t(2, "t3a_done");
        chk("t3a_done", 32'(done), 32'h1);
        cyc(); req = '0; cyc();
        limit = 16'h000F; req = 4'b0001;
        wait_t(8, "t3b_cnt7");
        chk("t3b_cnt7",   32'(count),  32'h7);
        chk("t3b_tog7",   32'(toggle), 32'hF);
        wait_t(17, "t3b_done");
        chk("t3b_count15", 32'(count), 32'hF);
        chk("t3b_done",    32'(done),  32'h1);
        cyc(); req = '0; cyc();

        // 4: owner 1 limit 9, abort at count 5, next grant goes to 2
        limit = 16'h0C92; req = 4'b0111;
        cyc();
        chk("t4_grant1", 32'(grant), 32'h2);
        wait_t(6, "t4_cnt5");
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t4_abort_count", 32'(count), 32'h0);
        chk("t4_abort_grant", 32'(grant), 32'h0);
        cyc();
        chk("t4_next_grant", 32'(grant), 32'h4);

        // 5: owner 2 drops req at count 2; then a mid-job limit change is ignored
        limit = 16'h0000;
        wait_t(3, "t5_cnt2");
        req = 4'b0011;
        cyc();
        chk("t5_drop_busy", 32'(busy), 32'h0);
        chk("t5_drop_done", 32'(done), 32'h0);
        limit = 16'h0002; req = 4'b0001;
        cyc();
        chk("t5_grant0", 32'(grant), 32'h1);
        limit = 16'hFFFF;
        wait_t(4, "t5_done");
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_latched_limit", 32'(count), 32'h2);
        cyc(); req = '0; cyc();

        // 6: asynchronous reset between edges mid-count
        limit = 16'h00A0; req = 4'b0010;
        wait_t(7, "t6_cnt6");
        chk("t6_cnt6", 32'(count), 32'h6);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_grant",  32'(grant),  32'h0);
        chk("t6_rst_busy",   32'(busy),   32'h0);
        chk("t6_rst_count",  32'(count),  32'h0);
        chk("t6_rst_done",   32'(done),   32'h0);
        chk("t6_rst_toggle", 32'(toggle), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1001; limit = 16'h1111;
        cyc();
        chk("t6_rr0_grant", 32'(grant), 32'h1);
        wait_idle("t6_idle");
        req = '0;
        cyc();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            limit = 16'($urandom);
            abort = ($urandom_range(0, 19) == 0);
            cyc();
        end
        abort = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
